// File: rtl/sha1_pkg.sv
// Shared constants and state encoding for the SHA-1 block sequencer.
package sha1_pkg;

   typedef enum logic [2:0] {
      ST_DATA   = 3'd0,
      ST_PAD80  = 3'd1,
      ST_ZERO   = 3'd2,
      ST_LEN_HI = 3'd3,
      ST_LEN_LO = 3'd4
   } sha1_state_e;

   localparam logic [31:0] SHA1_PAD_WORD  = 32'h8000_0000;
   localparam int          SHA1_BLK_WORDS = 16;
   localparam int          SHA1_LEN_IDX   = 14;

endpackage

// File: rtl/sha1_block_sequencer.sv
// Drains a FIFO message stream into the SHA-1 core and appends the standard
// padding (0x80000000, zero fill, 64-bit big-endian bit length).
module sha1_block_sequencer
   import sha1_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int PRE_WORDS = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        s_tvalid,
   input  logic [31:0] s_tdata,
   input  logic        s_tlast,
   output logic        s_tready,
   output logic        o_tvalid,
   output logic [31:0] o_tdata,
   input  logic        i_tready,
   output logic [3:0]  o_word_idx,
   output logic        o_blk_end,
   output logic        o_tlast,
   output logic        o_busy
);

   // Six extra bits hold the *32 scaling plus the PRE_WORDS carry without loss.
   localparam int LEN_W = CNT_W + 6;

   sha1_state_e      state_r;
   sha1_state_e      state_nxt_s;
   logic [3:0]       word_idx_r;
   logic [3:0]       word_idx_nxt_s;
   logic [3:0]       idx_inc_s;
   logic [CNT_W-1:0] wcnt_r;
   logic [CNT_W-1:0] wcnt_nxt_s;
   logic [LEN_W-1:0] len_words_s;
   logic [63:0]      bitlen_s;
   logic             out_hs_s;

   assign len_words_s = LEN_W'(wcnt_r) + LEN_W'(PRE_WORDS);
   assign bitlen_s    = 64'(len_words_s) << 5;
   assign idx_inc_s   = word_idx_r + 4'd1;

   assign o_tvalid   = (state_r == ST_DATA) ? s_tvalid : 1'b1;
   assign out_hs_s   = o_tvalid & i_tready;
   assign o_word_idx = word_idx_r;
   assign o_blk_end  = o_tvalid && (word_idx_r == 4'(SHA1_BLK_WORDS - 1));
   assign o_busy     = (state_r != ST_DATA) || (wcnt_r != '0);

   // Next-state, counter updates and output word mux.
   always_comb begin
      state_nxt_s    = state_r;
      word_idx_nxt_s = word_idx_r;
      wcnt_nxt_s     = wcnt_r;
      s_tready       = 1'b0;
      o_tdata        = 32'h0000_0000;
      o_tlast        = 1'b0;
      case (state_r)
         ST_DATA: begin
            s_tready = i_tready;
            o_tdata  = s_tdata;
            if (out_hs_s) begin
               word_idx_nxt_s = idx_inc_s;
               wcnt_nxt_s     = wcnt_r + CNT_W'(1);
               if (s_tlast) begin
                  state_nxt_s = ST_PAD80;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else begin
               word_idx_nxt_s = word_idx_r;
            end
         end
         ST_PAD80: begin
            o_tdata = SHA1_PAD_WORD;
            if (out_hs_s) begin
               word_idx_nxt_s = idx_inc_s;
               if (idx_inc_s == 4'(SHA1_LEN_IDX)) begin
                  state_nxt_s = ST_LEN_HI;
               end else begin
                  state_nxt_s = ST_ZERO;
               end
            end else begin
               word_idx_nxt_s = word_idx_r;
            end
         end
         ST_ZERO: begin
            if (out_hs_s) begin
               word_idx_nxt_s = idx_inc_s;
               if (word_idx_r == 4'(SHA1_LEN_IDX - 1)) begin
                  state_nxt_s = ST_LEN_HI;
               end else begin
                  state_nxt_s = ST_ZERO;
               end
            end else begin
               word_idx_nxt_s = word_idx_r;
            end
         end
         ST_LEN_HI: begin
            o_tdata = bitlen_s[63:32];
            if (out_hs_s) begin
               word_idx_nxt_s = idx_inc_s;
               state_nxt_s    = ST_LEN_LO;
            end else begin
               word_idx_nxt_s = word_idx_r;
            end
         end
         ST_LEN_LO: begin
            o_tdata = bitlen_s[31:0];
            o_tlast = 1'b1;
            if (out_hs_s) begin
               word_idx_nxt_s = 4'd0;
               wcnt_nxt_s     = '0;
               state_nxt_s    = ST_DATA;
            end else begin
               word_idx_nxt_s = word_idx_r;
            end
         end
         default: begin
            state_nxt_s    = ST_DATA;
            word_idx_nxt_s = 4'd0;
            wcnt_nxt_s     = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r    <= ST_DATA;
         word_idx_r <= 4'd0;
         wcnt_r     <= '0;
      end else begin
         state_r    <= state_nxt_s;
         word_idx_r <= word_idx_nxt_s;
         wcnt_r     <= wcnt_nxt_s;
      end
   end

endmodule
